mem_stage_access_ctrl: RTL and testbench

//  Memory-stage consumer of the EX/MEM pipeline register: takes wmem/rmem, address, store data
//  and destination fields and performs the data-memory transaction over a req/ack handshake.

---
 rtl/mem_stage_access_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mem_stage_access_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_access_ctrl.sv
// MEM stage access controller: runs the data-memory req/ack transaction,
// stalls the pipeline while busy and emits a registered writeback bundle.
module mem_stage_access_ctrl #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_wmem,
  input  logic              in_rmem,
  input  logic              in_wreg,
  input  logic [REG_W-1:0]  in_dest,
  input  logic [DATA_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic              wb_wreg,
  output logic [REG_W-1:0]  wb_dest,
  output logic [DATA_W-1:0] wb_data,
  output logic              err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    IDLE,
    REQ
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              lwreg_q, lwreg_d;
  logic [REG_W-1:0]  ldest_q, ldest_d;
  logic              wbv_q, wbv_d;
  logic              wbw_q, wbw_d;
  logic [REG_W-1:0]  wbd_q, wbd_d;
  logic [DATA_W-1:0] wbx_q, wbx_d;
  logic              err_q, err_d;

  logic              op_mem;
  logic              op_ill;
  logic              op_alu;
  logic [CW-1:0]     cnt_inc;

  assign op_mem  = in_wmem ^ in_rmem;
  assign op_ill  = in_wmem & in_rmem;
  assign op_alu  = ~(in_wmem | in_rmem);
  assign cnt_inc = cnt_q + CW'(1);

  // Next-state and writeback bundle computation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    lwreg_d = lwreg_q;
    ldest_d = ldest_q;
    wbv_d   = 1'b0;
    wbw_d   = wbw_q;
    wbd_d   = wbd_q;
    wbx_d   = wbx_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          unique case (1'b1)
            op_mem: begin
              state_d = REQ;
              cnt_d   = '0;
              we_d    = in_wmem;
              addr_d  = in_addr;
              wdata_d = in_wdata;
              lwreg_d = in_wreg;
              ldest_d = in_dest;
            end
            op_ill: begin
              err_d = 1'b1;
              wbv_d = 1'b1;
              wbw_d = 1'b0;
              wbd_d = in_dest;
              wbx_d = in_addr;
            end
            op_alu: begin
              wbv_d = 1'b1;
              wbw_d = in_wreg;
              wbd_d = in_dest;
              wbx_d = in_addr;
            end
            default: ;
          endcase
        end
      end
      REQ: begin
        cnt_d = cnt_inc;
        if (mem_ack) begin
          state_d = IDLE;
          wbv_d   = 1'b1;
          wbd_d   = ldest_q;
          if (we_q) begin
            wbw_d = 1'b0;
            wbx_d = addr_q;
          end else begin
            wbw_d = lwreg_q;
            wbx_d = mem_rdata;
          end
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          state_d = IDLE;
          err_d   = 1'b1;
          wbv_d   = 1'b1;
          wbw_d   = 1'b0;
          wbd_d   = ldest_q;
          wbx_d   = addr_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      lwreg_q <= 1'b0;
      ldest_q <= '0;
      wbv_q   <= 1'b0;
      wbw_q   <= 1'b0;
      wbd_q   <= '0;
      wbx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lwreg_q <= lwreg_d;
      ldest_q <= ldest_d;
      wbv_q   <= wbv_d;
      wbw_q   <= wbw_d;
      wbd_q   <= wbd_d;
      wbx_q   <= wbx_d;
      err_q   <= err_d;
    end
  end

  assign stall     = (state_q == REQ);
  assign mem_req   = (state_q == REQ);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign wb_valid  = wbv_q;
  assign wb_wreg   = wbw_q;
  assign wb_dest   = wbd_q;
  assign wb_data   = wbx_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_stage_access_ctrl.sv
// Bench for mem_stage_access_ctrl: random op stream, transaction-level
// model feeds a scoreboard queue, monitor compares every cycle.
module tb_mem_stage_access_ctrl;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_wmem, in_rmem, in_wreg;
  logic [3:0]  in_dest;
  logic [31:0] in_addr, in_wdata;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid, wb_wreg;
  logic [3:0]  wb_dest;
  logic [31:0] wb_data;
  logic        err;

  mem_stage_access_ctrl #(
    .DATA_W(32), .REG_W(4), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_wmem(in_wmem),
    .in_rmem(in_rmem), .in_wreg(in_wreg),
    .in_dest(in_dest), .in_addr(in_addr),
    .in_wdata(in_wdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_wreg(wb_wreg),
    .wb_dest(wb_dest), .wb_data(wb_data),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wreg;
    logic [3:0]  dest;
    logic [31:0] data;
    bit          chk_dd;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  bit          mon_en = 0;
  bit          exp_req = 0;
  bit          exp_wbv = 0;
  bit          exp_err = 0;
  bit          exp_we = 0;
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_wdata = '0;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the model each cycle
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (mon_en) begin
      chk("stall", stall, exp_req);
      chk("mem_req", mem_req, exp_req);
      if (exp_req) begin
        chk("mem_we", mem_we, exp_we);
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_wdata", mem_wdata, exp_wdata);
      end
      chk("err", err, exp_err);
      chk("wb_valid", wb_valid, exp_wbv);
      if (wb_valid) begin
        if (q.size() == 0) begin
          chk("wb_unexpected", 1, 0);
        end else begin
          e = q.pop_front();
          chk("wb_wreg", wb_wreg, e.wreg);
          if (e.chk_dd) begin
            chk("wb_dest", wb_dest, e.dest);
            chk("wb_data", wb_data, e.data);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    in_valid  = 1'b0;
    in_wmem   = 1'($urandom);
    in_rmem   = 1'($urandom);
    in_wreg   = 1'($urandom);
    in_dest   = 4'($urandom);
    in_addr   = $urandom;
    in_wdata  = $urandom;
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    exp_wbv   = 0;
  endtask

  task automatic gap(bit stray);
    cyc();
    mem_ack = stray;
    exp_req = 0;
  endtask

  // kind: 0 alu, 1 load, 2 store, 3 illegal; k > TO means no ack
  task automatic run_op(int kind, logic wreg, logic [3:0] dest,
                        logic [31:0] addr, logic [31:0] wdata,
                        int k, logic [31:0] rd);
    exp_t e;
    cyc();
    in_valid = 1'b1;
    in_wmem  = (kind == 2 || kind == 3);
    in_rmem  = (kind == 1 || kind == 3);
    in_wreg  = wreg;
    in_dest  = dest;
    in_addr  = addr;
    in_wdata = wdata;
    mem_ack  = 1'($urandom);
    if (kind == 0) begin
      e = '{wreg, dest, addr, 1'b1};
      q.push_back(e);
      exp_wbv = 1;
      exp_req = 0;
    end else if (kind == 3) begin
      e = '{1'b0, dest, addr, 1'b0};
      q.push_back(e);
      exp_wbv = 1;
      exp_err = 1;
      exp_req = 0;
    end else begin
      exp_req   = 1;
      exp_we    = (kind == 2);
      exp_addr  = addr;
      exp_wdata = wdata;
      for (int j = 1; j <= TO; j++) begin
        cyc();
        in_valid = 1'($urandom);
        if (j == k) begin
          mem_ack   = 1'b1;
          mem_rdata = rd;
          exp_req   = 0;
          exp_wbv   = 1;
          if (kind == 2) e = '{1'b0, dest, addr, 1'b1};
          else           e = '{wreg, dest, rd, 1'b1};
          q.push_back(e);
          break;
        end
        if (j == TO) begin
          exp_req = 0;
          exp_wbv = 1;
          exp_err = 1;
          e = '{1'b0, dest, addr, 1'b0};
          q.push_back(e);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 0; in_wmem = 0; in_rmem = 0; in_wreg = 0;
    in_dest = '0; in_addr = '0; in_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
    #3;
    chk("rst_stall", stall, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_wreg", wb_wreg, 0);
    chk("rst_wb_dest", wb_dest, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1;

    run_op(0, 1, 4'd5, 32'h1234, 32'h0, 0, 0);
    run_op(1, 1, 4'd3, 32'h40, 32'h0, 3, 32'hDEADBEEF);
    run_op(2, 1, 4'd7, 32'h80, 32'hA5A5A5A5, 1, 32'h0);
    run_op(1, 1, 4'd9, 32'h44, 32'h0, TO, 32'h0BADF00D);
    run_op(1, 1, 4'd2, 32'h48, 32'h0, TO + 1, 32'h0);
    run_op(0, 1, 4'd6, 32'h5678, 32'h0, 0, 0);
    run_op(3, 1, 4'd1, 32'h99, 32'h0, 0, 0);
    gap(1);
    gap(1);
    run_op(0, 1, 4'd8, 32'h9ABC, 32'h0, 0, 0);
    run_op(0, 0, 4'd4, 32'hCAFE, 32'h0, 0, 0);

    cyc();
    in_valid = 1; in_rmem = 1; in_wmem = 0;
    in_addr = 32'h100; in_dest = 4'd2;
    exp_req = 1; exp_we = 0;
    exp_addr = 32'h100; exp_wdata = in_wdata;
    cyc();
    cyc();
    #1;
    mon_en = 0;
    rst = 1'b0;
    #1;
    chk("arst_mem_req", mem_req, 0);
    chk("arst_stall", stall, 0);
    chk("arst_wb_valid", wb_valid, 0);
    chk("arst_err", err, 0);
    q.delete();
    exp_err = 0; exp_req = 0; exp_wbv = 0;
    @(negedge clk);
    in_valid = 0;
    rst = 1'b1;
    mon_en = 1;

    for (int n = 0; n < 300; n++) begin
      int kind, k, r;
      r = $urandom_range(0, 19);
      if (r < 6)       kind = 0;
      else if (r < 12) kind = 1;
      else if (r < 18) kind = 2;
      else             kind = 3;
      k = ($urandom_range(0, 9) == 0) ? TO + 1
                                      : $urandom_range(1, TO);
      run_op(kind, 1'($urandom), 4'($urandom), $urandom,
             $urandom, k, $urandom);
      if ($urandom_range(0, 2) == 0) begin
        int g;
        g = $urandom_range(1, 3);
        for (int i = 0; i < g; i++) gap(1'($urandom));
      end
    end
    gap(0);
    gap(0);
    @(posedge clk);
    #2;
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
